prover_round_ctrl: RTL

Hardware sumcheck round sequencer for one or more parallel `prover_synth_test`-class prover instances. It supplies fresh challenges (`tau`), issues per-round `en`/`restart` and the final `comp_w0`, and aggregates ready pulses across NCH prover channels. It checks that channels agree on `ready_code`, enforces a per-round timeout, and reports per-round and total cycle counts. It sits between the challenge source (PRNG or host) and the prover array.

---
 rtl/prover_round_ctrl.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/prover_round_ctrl.sv
// prover_round_ctrl: sumcheck round sequencer for NCH lockstep prover channels.
// Hands out challenges, pulses en/restart/comp_w0, aggregates ready pulses, times rounds.
module prover_round_ctrl #(
    parameter int NCH     = 2,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096,
    parameter int RND_W   = 8,
    parameter int F_NBITS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [RND_W-1:0]   exp_rounds,
    input  logic [F_NBITS-1:0] tau_in,
    input  logic               tau_valid,
    output logic               tau_req,
    input  logic [NCH-1:0]     ready_pulse,
    input  logic [2*NCH-1:0]   ready_code,
    input  logic [NCH-1:0]     w0_ready_pulse,
    output logic               en,
    output logic               restart,
    output logic               comp_w0,
    output logic [F_NBITS-1:0] tau_out,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2:0]         err_code,
    output logic [RND_W-1:0]   round_cnt,
    output logic [CNT_W-1:0]   last_cycles,
    output logic [CNT_W-1:0]   total_cycles
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WLAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] E_CODE  = 3'b001;
    localparam logic [2:0] E_TMO   = 3'b010;
    localparam logic [2:0] E_SPUR  = 3'b011;
    localparam logic [2:0] E_ROUND = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE, S_TAU, S_ISSUE, S_WAIT, S_TAU_W0,
        S_ISSUE_W0, S_WAIT_W0, S_DONE, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [F_NBITS-1:0] tau_out_q, tau_out_d;
    logic               err_q, err_d;
    logic [2:0]         err_code_q, err_code_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic [RND_W-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [CNT_W-1:0]   rcyc_q, rcyc_d;
    logic [TW-1:0]      wcnt_q, wcnt_d;
    logic               first_q, first_d;
    logic [NCH-1:0]     seen_q, seen_d;
    logic [2*NCH-1:0]   code_q, code_d;
    logic               tau_req_q, tau_req_d;
    logic               en_q, en_d;
    logic               restart_q, restart_d;
    logic               comp_w0_q, comp_w0_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [2*NCH-1:0]   mcode;
    logic               mism;
    logic               rp_any, wp_any;
    logic               rp_all, wp_all;
    logic               rp_dup, wp_dup;
    logic               err_hit;
    logic [2:0]         err_sel;
    logic [RND_W-1:0]   round_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Codes of channels already seen come from the capture regs, others from the port.
    always_comb begin
        mcode = '0;
        mism  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            mcode[2*c +: 2] = seen_q[c] ? code_q[2*c +: 2] : ready_code[2*c +: 2];
        end
        for (int c = 1; c < NCH; c++) begin
            if (mcode[2*c +: 2] != mcode[1:0]) mism = 1'b1;
        end
    end

    assign rp_any    = |ready_pulse;
    assign wp_any    = |w0_ready_pulse;
    assign rp_all    = &(seen_q | ready_pulse);
    assign wp_all    = &(seen_q | w0_ready_pulse);
    assign rp_dup    = |(seen_q & ready_pulse);
    assign wp_dup    = |(seen_q & w0_ready_pulse);
    assign round_inc = round_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        tau_out_d  = tau_out_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        round_d    = round_q;
        exp_d      = exp_q;
        last_d     = last_q;
        total_d    = total_q;
        rcyc_d     = rcyc_q;
        wcnt_d     = wcnt_q;
        first_d    = first_q;
        seen_d     = seen_q;
        code_d     = code_q;
        err_hit    = 1'b0;
        err_sel    = 3'b000;

        // Run time spans first ISSUE through the final w0 pulse.
        if ((state_q == S_ISSUE) || (state_q == S_WAIT) ||
            (state_q == S_TAU_W0) || (state_q == S_ISSUE_W0) ||
            (state_q == S_WAIT_W0) || ((state_q == S_TAU) && !first_q)) begin
            total_d = sat_inc(total_q);
        end

        case (state_q)
            S_TAU, S_TAU_W0: begin
                if (rp_any || wp_any) begin
                    err_hit = 1'b1;
                    err_sel = E_SPUR;
                end else if (tau_valid && tau_req_q) begin
                    tau_out_d = tau_in;
                    state_d   = (state_q == S_TAU) ? S_ISSUE : S_ISSUE_W0;
                end
            end
            S_ISSUE, S_ISSUE_W0: begin
                if (rp_any || wp_any) begin
                    err_hit = 1'b1;
                    err_sel = E_SPUR;
                end else begin
                    state_d = (state_q == S_ISSUE) ? S_WAIT : S_WAIT_W0;
                    first_d = 1'b0;
                    rcyc_d  = CNT_W'(1);
                    wcnt_d  = '0;
                    seen_d  = '0;
                end
            end
            S_WAIT: begin
                if (wp_any || rp_dup) begin
                    err_hit = 1'b1;
                    err_sel = E_SPUR;
                end else if (rp_all) begin
                    if (mism) begin
                        err_hit = 1'b1;
                        err_sel = E_CODE;
                    end else begin
                        round_d = round_inc;
                        last_d  = sat_inc(rcyc_q);
                        if (!mcode[1]) begin
                            state_d = S_TAU;
                        end else if (round_inc != exp_q) begin
                            err_hit = 1'b1;
                            err_sel = E_ROUND;
                        end else begin
                            state_d = S_TAU_W0;
                        end
                    end
                end else begin
                    seen_d = seen_q | ready_pulse;
                    for (int c = 0; c < NCH; c++) begin
                        if (ready_pulse[c]) code_d[2*c +: 2] = ready_code[2*c +: 2];
                    end
                    rcyc_d = sat_inc(rcyc_q);
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WLAST) begin
                        err_hit = 1'b1;
                        err_sel = E_TMO;
                    end
                end
            end
            S_WAIT_W0: begin
                if (rp_any || wp_dup) begin
                    err_hit = 1'b1;
                    err_sel = E_SPUR;
                end else if (wp_all) begin
                    state_d = S_DONE;
                end else begin
                    seen_d = seen_q | w0_ready_pulse;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WLAST) begin
                        err_hit = 1'b1;
                        err_sel = E_TMO;
                    end
                end
            end
            S_DONE: begin
                if (rp_any || wp_any) begin
                    err_hit = 1'b1;
                    err_sel = E_SPUR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        if (err_hit) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = err_sel;
        end

        // ERR accepts start as a fresh run, so both idle states share this path.
        if (start && ((state_q == S_IDLE) || (state_q == S_ERR))) begin
            state_d    = S_TAU;
            err_d      = 1'b0;
            err_code_d = 3'b000;
            round_d    = '0;
            last_d     = '0;
            total_d    = '0;
            rcyc_d     = '0;
            wcnt_d     = '0;
            seen_d     = '0;
            code_d     = '0;
            exp_d      = exp_rounds;
            first_d    = 1'b1;
        end

        tau_req_d = (state_d == S_TAU) || (state_d == S_TAU_W0);
        en_d      = (state_d == S_ISSUE);
        restart_d = (state_d == S_ISSUE) && first_d;
        comp_w0_d = (state_d == S_ISSUE_W0);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tau_out_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= 3'b000;
            round_q    <= '0;
            exp_q      <= '0;
            last_q     <= '0;
            total_q    <= '0;
            rcyc_q     <= '0;
            wcnt_q     <= '0;
            first_q    <= 1'b0;
            seen_q     <= '0;
            code_q     <= '0;
            tau_req_q  <= 1'b0;
            en_q       <= 1'b0;
            restart_q  <= 1'b0;
            comp_w0_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tau_out_q  <= tau_out_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            round_q    <= round_d;
            exp_q      <= exp_d;
            last_q     <= last_d;
            total_q    <= total_d;
            rcyc_q     <= rcyc_d;
            wcnt_q     <= wcnt_d;
            first_q    <= first_d;
            seen_q     <= seen_d;
            code_q     <= code_d;
            tau_req_q  <= tau_req_d;
            en_q       <= en_d;
            restart_q  <= restart_d;
            comp_w0_q  <= comp_w0_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tau_req      = tau_req_q;
    assign en           = en_q;
    assign restart      = restart_q;
    assign comp_w0      = comp_w0_q;
    assign tau_out      = tau_out_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign round_cnt    = round_q;
    assign last_cycles  = last_q;
    assign total_cycles = total_q;

endmodule
